// File: rtl/tdm_demux_1_n_pkg.sv
// Shared types and helpers for the TDM demultiplexer slice.
// The TDM mux side imports the same state encoding.
package tdm_demux_1_n_pkg;

    typedef enum logic {
        ST_HUNT = 1'b0,
        ST_LOCK = 1'b1
    } tdm_state_e;

    function automatic int unsigned slot_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tdm_demux_1_n_if.sv
// TDM demux bus: serial word input side plus per-channel output side.
interface tdm_demux_1_n_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DATA_W = 8
);
    logic                     in_valid;
    logic [DATA_W-1:0]        in_data;
    logic                     in_sync;
    logic [NUM_CH*DATA_W-1:0] out_data;
    logic [NUM_CH-1:0]        out_valid;
    logic                     frame_done;
    logic                     locked;
    logic                     sync_err;

    modport master (
        output in_valid, in_data, in_sync,
        input  out_data, out_valid, frame_done, locked, sync_err
    );

    modport slave (
        input  in_valid, in_data, in_sync,
        output out_data, out_valid, frame_done, locked, sync_err
    );
endinterface

// File: rtl/tdm_demux_1_n_ch_reg.sv
// One channel holding register: loads on enable, emits a 1-cycle valid strobe.
module tdm_ch_reg #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q,
    output logic              vld
);
    logic [DATA_W-1:0] data_q, data_d;
    logic              vld_q, vld_d;

    always_comb begin
        data_d = load ? d : data_q;
        vld_d  = load;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
        end
    end

    assign q   = data_q;
    assign vld = vld_q;
endmodule

// File: rtl/tdm_demux_1_n.sv
// TDM demultiplexer: hunts for in_sync, then steers each accepted word
// round-robin into its channel register with one cycle of latency.
module tdm_demux_1_n
    import tdm_demux_1_n_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DATA_W = 8
) (
    input logic             clk,
    input logic             rst_n,
    tdm_demux_1_n_if.slave  bus
);
    localparam int unsigned      SLOT_W    = slot_width(NUM_CH);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_CH - 1);
    localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);

    tdm_state_e        state_q, state_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic              frame_done_q, frame_done_d;
    logic              sync_err_q, sync_err_d;
    logic              wr;
    logic [SLOT_W-1:0] wr_ch;
    logic [NUM_CH-1:0] wr_en;

    logic [DATA_W-1:0] ch_data [NUM_CH];
    logic              ch_vld  [NUM_CH];

    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        sync_err_d = 1'b0;
        wr       = 1'b0;
        wr_ch    = '0;
        if (bus.in_valid) begin
            case (state_q)
                ST_HUNT: begin
                    if (bus.in_sync) begin
                        wr      = 1'b1;
                        slot_d  = SLOT_ONE;
                        state_d = ST_LOCK;
                    end
                end
                ST_LOCK: begin
                    // Misplaced sync restarts the frame at ch0; the aborted frame never reaches the last slot.
                    if (bus.in_sync && (slot_q != '0)) begin
                        sync_err_d = 1'b1;
                        wr         = 1'b1;
                        slot_d     = SLOT_ONE;
                    end else begin
                        wr     = 1'b1;
                        wr_ch  = slot_q;
                        slot_d = (slot_q == LAST_SLOT) ? '0 : slot_q + SLOT_ONE;
                    end
                end
                default: ;
            endcase
        end
        wr_en = '0;
        if (wr) wr_en[wr_ch] = 1'b1;
        frame_done_d = wr && (wr_ch == LAST_SLOT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_HUNT;
            slot_q       <= '0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        tdm_ch_reg #(
            .DATA_W(DATA_W)
        ) u_ch_reg (
            .clk  (clk),
            .rst_n(rst_n),
            .load (wr_en[k]),
            .d    (bus.in_data),
            .q    (ch_data[k]),
            .vld  (ch_vld[k])
        );
    end

    always_comb begin
        bus.out_data  = '0;
        bus.out_valid = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            bus.out_data[k*DATA_W +: DATA_W] = ch_data[k];
            bus.out_valid[k]                 = ch_vld[k];
        end
    end

    assign bus.frame_done = frame_done_q;
    assign bus.sync_err   = sync_err_q;
    assign bus.locked     = (state_q == ST_LOCK);
endmodule
